ddram_responder: RTL and testbench

- Responder end of the DDRAM Avalon-style burst interface: accepts the read/write commands the memory arbiter issues and answers them from a local 64-bit BRAM window.
- Provides DDRAM_BUSY, DDRAM_DOUT and DDRAM_DOUT_READY with configurable read latency and busy injection.
- Used in simulation and in on-FPGA bring-up builds in place of the HPS DDR3 port.

---
 rtl/ddram_pkg.sv | 14 +
 rtl/ddram_responder_if.sv | 18 +
 rtl/ddram_resp_mem.sv | 27 ++
 rtl/ddram_responder.sv | 121 ++++++++++++
 tb/tb_ddram_responder.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddram_pkg.sv
// Shared types and constants for the DDRAM responder slice.
package ddram_pkg;
  localparam int DDRAM_AW  = 29;
  localparam int DDRAM_DW  = 64;
  localparam int DDRAM_BEW = 8;
  localparam logic [3:0] REGION_HPS_30000000 = 4'b0011;

  typedef enum logic [1:0] {IDLE, WBURST, RWAIT, RBEAT} resp_state_t;

  // A zero burst count is serviced as a single beat.
  function automatic logic [7:0] burst_len(input logic [7:0] cnt);
    return (cnt == 8'd0) ? 8'd1 : cnt;
  endfunction
endpackage

// File: rtl/ddram_responder_if.sv
// DDRAM Avalon-style burst bus as seen between the memory arbiter and a responder.
interface ddram_responder_if;
  import ddram_pkg::*;
  logic [7:0]           DDRAM_BURSTCNT;
  logic [DDRAM_AW-1:0]  DDRAM_ADDR;
  logic                 DDRAM_RD;
  logic                 DDRAM_WE;
  logic [DDRAM_DW-1:0]  DDRAM_DIN;
  logic [DDRAM_BEW-1:0] DDRAM_BE;
  logic                 DDRAM_BUSY;
  logic [DDRAM_DW-1:0]  DDRAM_DOUT;
  logic                 DDRAM_DOUT_READY;

  modport master (output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE,
                  input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY);
  modport slave  (input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE,
                  output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY);
endinterface

// File: rtl/ddram_resp_mem.sv
// Single-port 2^AW x 64 RAM, per-byte write enable, registered write-first read.
module ddram_resp_mem
  import ddram_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic                 clk,
  input  logic [AW-1:0]        addr,
  input  logic                 we,
  input  logic [DDRAM_BEW-1:0] be,
  input  logic [DDRAM_DW-1:0]  wdata,
  output logic [DDRAM_DW-1:0]  q
);
  for (genvar b = 0; b < DDRAM_BEW; b++) begin : g_lane
    logic [7:0] lane [2**AW];
    logic [7:0] lane_q;
    always_ff @(posedge clk) begin
      if (we && be[b]) begin
        lane[addr] <= wdata[8*b +: 8];
        lane_q     <= wdata[8*b +: 8];
      end else begin
        lane_q     <= lane[addr];
      end
    end
    assign q[8*b +: 8] = lane_q;
  end
endmodule

// File: rtl/ddram_responder.sv
// Answers DDRAM arbiter bursts from a local BRAM window, with programmable
// read latency and optional periodic busy injection.
module ddram_responder
  import ddram_pkg::*;
#(
  parameter int         AW         = 12,
  parameter logic [3:0] REGION     = REGION_HPS_30000000,
  parameter int         RD_LAT     = 4,
  parameter int         BUSY_EVERY = 0
) (
  input  logic             DDRAM_CLK,
  input  logic             DDRAM_RESET_N,
  ddram_responder_if.slave bus,
  output logic             proto_err
);
  resp_state_t         state;
  logic                live, busy, inj, idle_acc, rd_issue, rd_vld;
  logic                cmd_win, wr_win, rd_win, mem_we;
  logic [AW-1:0]       cmd_idx, wr_idx, rd_idx, mem_addr;
  logic [7:0]          cmd_len, wr_rem, rd_rem;
  logic [3:0]          wait_cnt;
  logic [15:0]         inj_cnt;
  logic [DDRAM_DW-1:0] mem_q, dout, dout_q;
  logic                unused_addr;

  assign unused_addr = ^bus.DDRAM_ADDR[24:AW];
  assign cmd_win  = bus.DDRAM_ADDR[28:25] == REGION;
  assign cmd_idx  = bus.DDRAM_ADDR[AW-1:0];
  assign cmd_len  = burst_len(bus.DDRAM_BURSTCNT);

  // Busy is held until the first edge after reset release.
  assign inj      = (BUSY_EVERY != 0) && state == IDLE && inj_cnt == 16'(BUSY_EVERY);
  assign busy     = !live || state == RWAIT || state == RBEAT || inj;
  assign idle_acc = state == IDLE && !busy && (bus.DDRAM_RD || bus.DDRAM_WE);
  assign rd_issue = state == RBEAT && rd_rem != 8'd0;

  assign mem_we   = bus.DDRAM_WE && ((idle_acc && cmd_win) || (state == WBURST && wr_win));
  assign mem_addr = (state == WBURST) ? wr_idx : (state == RBEAT) ? rd_idx : cmd_idx;

  ddram_resp_mem #(.AW(AW)) u_mem (
    .clk(DDRAM_CLK), .addr(mem_addr), .we(mem_we), .be(bus.DDRAM_BE),
    .wdata(bus.DDRAM_DIN), .q(mem_q)
  );

  // Out-of-window reads keep normal timing but return zero.
  assign dout                 = rd_vld ? (rd_win ? mem_q : '0) : dout_q;
  assign bus.DDRAM_DOUT       = dout;
  assign bus.DDRAM_DOUT_READY = rd_vld;
  assign bus.DDRAM_BUSY       = busy;

  always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
    if (!DDRAM_RESET_N) begin
      state     <= IDLE;
      live      <= 1'b0;
      proto_err <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      wr_rem    <= '0;
      rd_rem    <= '0;
      wait_cnt  <= '0;
      inj_cnt   <= '0;
      wr_win    <= 1'b0;
      rd_win    <= 1'b0;
      rd_vld    <= 1'b0;
      dout_q    <= '0;
    end else begin
      live   <= 1'b1;
      rd_vld <= rd_issue;
      if (rd_vld) dout_q <= dout;

      if (idle_acc && (bus.DDRAM_BURSTCNT == 8'd0 || (bus.DDRAM_RD && bus.DDRAM_WE)))
        proto_err <= 1'b1;
      if (state == WBURST && bus.DDRAM_RD)
        proto_err <= 1'b1;

      if (state != IDLE || idle_acc || inj) inj_cnt <= '0;
      else if (!busy)                       inj_cnt <= inj_cnt + 16'd1;

      case (state)
        IDLE: if (idle_acc) begin
          if (bus.DDRAM_WE) begin
            if (cmd_len != 8'd1) begin
              wr_rem <= cmd_len - 8'd1;
              wr_idx <= cmd_idx + AW'(1);
              wr_win <= cmd_win;
              state  <= WBURST;
            end
          end else begin
            rd_idx <= cmd_idx;
            rd_rem <= cmd_len;
            rd_win <= cmd_win;
            if (RD_LAT > 2) begin
              wait_cnt <= 4'(RD_LAT - 3);
              state    <= RWAIT;
            end else begin
              state    <= RBEAT;
            end
          end
        end
        WBURST: if (bus.DDRAM_WE) begin
          wr_idx <= wr_idx + AW'(1);
          wr_rem <= wr_rem - 8'd1;
          if (wr_rem == 8'd1) state <= IDLE;
        end
        RWAIT: begin
          if (wait_cnt == 4'd0) state <= RBEAT;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        RBEAT: begin
          if (rd_issue) begin
            rd_idx <= rd_idx + AW'(1);
            rd_rem <= rd_rem - 8'd1;
          end
          // Last beat is on the bus this cycle; drop busy next cycle.
          if (rd_rem == 8'd0 && rd_vld) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddram_responder.sv
// Bench for ddram_responder: vector table, directed corner sequences and a
// randomized burst mix checked against a flat array memory model.
module tb_ddram_responder;
  import ddram_pkg::*;
  localparam int AW     = 12;
  localparam int DEPTH  = 1 << AW;
  localparam int RD_LAT = 4;
  localparam logic [28:0] WIN = 29'h6000000;
  localparam logic [28:0] OOW = 29'h8000000;

  typedef struct {
    bit          wr;
    logic [28:0] addr;
    logic [7:0]  cnt;
    logic [63:0] din;
    logic [7:0]  be;
    logic [63:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic perr0, perr1;
  int checks = 0;
  int failures = 0;
  logic [63:0] mdl [DEPTH];
  vec_t tbl [9];

  ddram_responder_if if0 ();
  ddram_responder_if if1 ();

  ddram_responder #(.AW(AW), .REGION(REGION_HPS_30000000), .RD_LAT(RD_LAT), .BUSY_EVERY(0)) dut0 (
    .DDRAM_CLK(clk), .DDRAM_RESET_N(rst_n), .bus(if0.slave), .proto_err(perr0));
  ddram_responder #(.AW(AW), .REGION(REGION_HPS_30000000), .RD_LAT(RD_LAT), .BUSY_EVERY(3)) dut1 (
    .DDRAM_CLK(clk), .DDRAM_RESET_N(rst_n), .bus(if1.slave), .proto_err(perr1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chkb(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] be);
    logic [63:0] r = old;
    for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (if0.DDRAM_BUSY && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles", if0.DDRAM_BUSY, n);
    end
  endtask

  // Called at a negedge; returns at the negedge after the last beat was taken.
  task automatic do_write(input logic [28:0] addr, input int cnt, input logic [7:0] be,
                          input logic [63:0] din, input logic [63:0] step, input int stall_at,
                          input bit also_rd);
    int  idx = int'(addr[AW-1:0]);
    bit  win = addr[28:25] == REGION_HPS_30000000;
    int  n   = (cnt == 0) ? 1 : cnt;
    int  k   = 0;
    bit  stalled = 0;
    logic [63:0] d;
    wait_idle();
    while (k < n) begin
      if (k == stall_at && !stalled) begin
        if0.DDRAM_WE = 1'b0;
        if0.DDRAM_RD = 1'b0;
        stalled = 1;
      end else begin
        d = din + 64'(k) * step;
        if0.DDRAM_WE       = 1'b1;
        if0.DDRAM_RD       = (k == 0) && also_rd;
        if0.DDRAM_ADDR     = (k == 0) ? addr : {4'b1111, 25'($urandom)};
        if0.DDRAM_BURSTCNT = 8'(cnt);
        if0.DDRAM_DIN      = d;
        if0.DDRAM_BE       = be;
        if (win) mdl[(idx + k) % DEPTH] = merge(mdl[(idx + k) % DEPTH], d, be);
        k++;
      end
      @(negedge clk);
    end
    if0.DDRAM_WE = 1'b0;
    if0.DDRAM_RD = 1'b0;
  endtask

  task automatic do_read(input logic [28:0] addr, input int cnt, output logic [63:0] first);
    int  idx = int'(addr[AW-1:0]);
    bit  win = addr[28:25] == REGION_HPS_30000000;
    int  n   = (cnt == 0) ? 1 : cnt;
    bit  rdy;
    logic [63:0] e = '0;
    first = '0;
    wait_idle();
    if0.DDRAM_RD       = 1'b1;
    if0.DDRAM_WE       = 1'b0;
    if0.DDRAM_ADDR     = addr;
    if0.DDRAM_BURSTCNT = 8'(cnt);
    @(negedge clk);
    if0.DDRAM_RD = 1'b0;
    for (int m = 1; m <= RD_LAT + n; m++) begin
      rdy = (m >= RD_LAT) && (m < RD_LAT + n);
      chkb("rd_ready", if0.DDRAM_DOUT_READY, rdy);
      chkb("rd_busy", if0.DDRAM_BUSY, m < RD_LAT + n);
      if (rdy) begin
        e = win ? mdl[(idx + m - RD_LAT) % DEPTH] : 64'd0;
        chk("rd_data", if0.DDRAM_DOUT, e);
        if (m == RD_LAT) first = if0.DDRAM_DOUT;
      end
      if (m < RD_LAT + n) @(negedge clk);
    end
    chk("dout_hold", if0.DDRAM_DOUT, e);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [63:0] first;
    bit saw;
    if0.DDRAM_RD = 0; if0.DDRAM_WE = 0; if0.DDRAM_ADDR = '0; if0.DDRAM_BURSTCNT = 8'd1;
    if0.DDRAM_DIN = '0; if0.DDRAM_BE = '0;
    if1.DDRAM_RD = 0; if1.DDRAM_WE = 0; if1.DDRAM_ADDR = '0; if1.DDRAM_BURSTCNT = 8'd1;
    if1.DDRAM_DIN = '0; if1.DDRAM_BE = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

    tbl[0] = '{1'b1, 29'h6000010, 8'd1, 64'h1122334455667788, 8'h0F, 64'h0};
    tbl[1] = '{1'b0, 29'h6000010, 8'd1, 64'h0, 8'h00, 64'h0000000055667788};
    tbl[2] = '{1'b1, 29'h6000010, 8'd1, 64'hAABBCCDDEEFF0011, 8'hC0, 64'h0};
    tbl[3] = '{1'b0, 29'h6000010, 8'd1, 64'h0, 8'h00, 64'hAABB000055667788};
    tbl[4] = '{1'b1, 29'h8000010, 8'd1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0};
    tbl[5] = '{1'b0, 29'h6000010, 8'd1, 64'h0, 8'h00, 64'hAABB000055667788};
    tbl[6] = '{1'b0, 29'h8000010, 8'd2, 64'h0, 8'h00, 64'h0};
    tbl[7] = '{1'b1, 29'h6001005, 8'd1, 64'h0123456789ABCDEF, 8'hFF, 64'h0};
    tbl[8] = '{1'b0, 29'h6000005, 8'd1, 64'h0, 8'h00, 64'h0123456789ABCDEF};

    // Reset values, then release
    repeat (2) @(negedge clk);
    chkb("rst_busy", if0.DDRAM_BUSY, 1'b1);
    chkb("rst_ready", if0.DDRAM_DOUT_READY, 1'b0);
    chk("rst_dout", if0.DDRAM_DOUT, 64'd0);
    chkb("rst_perr", perr0, 1'b0);
    rst_n = 1'b1;
    #1 chkb("rel_busy_hold", if0.DDRAM_BUSY, 1'b1);
    @(negedge clk);
    chkb("rel_busy_low", if0.DDRAM_BUSY, 1'b0);

    // Busy injection every 3 idle cycles
    for (int n = 0; n < 11; n++) begin
      chkb("inj_pattern", if1.DDRAM_BUSY, (n % 4) == 3);
      @(negedge clk);
    end
    chkb("inj_busy", if1.DDRAM_BUSY, 1'b1);
    if1.DDRAM_RD = 1'b1; if1.DDRAM_ADDR = WIN; if1.DDRAM_BURSTCNT = 8'd1;
    @(negedge clk);
    chkb("inj_not_taken", if1.DDRAM_BUSY, 1'b0);
    @(negedge clk);
    chkb("inj_taken", if1.DDRAM_BUSY, 1'b1);
    if1.DDRAM_RD = 1'b0;
    repeat (RD_LAT - 2) @(negedge clk);
    chkb("inj_rd_early", if1.DDRAM_DOUT_READY, 1'b0);
    @(negedge clk);
    chkb("inj_rd_ready", if1.DDRAM_DOUT_READY, 1'b1);
    @(negedge clk);
    chkb("inj_rd_done", if1.DDRAM_BUSY, 1'b0);
    chkb("inj_perr", perr1, 1'b0);

    // Zero the whole window so every later read has a known expectation
    for (int b = 0; b < DEPTH / 128; b++)
      do_write(WIN | 29'(b * 128), 128, 8'hFF, 64'd0, 64'd0, -1, 0);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].wr) do_write(tbl[i].addr, int'(tbl[i].cnt), tbl[i].be, tbl[i].din, 64'd0, -1, 0);
      else begin
        do_read(tbl[i].addr, int'(tbl[i].cnt), first);
        chk($sformatf("tbl_rd%0d", i), first, tbl[i].exp);
      end
    end
    chkb("perr_clean", perr0, 1'b0);

    // Wrapping burst with a mid-burst stall, read straight back
    do_write(WIN | 29'hFFE, 4, 8'hFF, 64'hDEAD_BEEF_0000_0001, 64'h0101_0101_0101_0101, 2, 0);
    do_read(WIN | 29'hFFE, 4, first);
    chk("wrap_first", first, 64'hDEAD_BEEF_0000_0001);
    do_read(WIN | 29'h000, 1, first);
    chk("wrap_idx0", first, 64'hDEAD_BEEF_0000_0001 + 64'h0202_0202_0202_0202);
    do_write(OOW | 29'hFFE, 2, 8'hFF, 64'h1234, 64'h1, -1, 0);
    do_read(WIN | 29'hFFE, 4, first);

    // Randomized mix against the model
    for (int t = 0; t < 40; t++) begin
      logic [28:0] a = {($urandom_range(0, 9) == 0) ? 4'b0100 : 4'b0011, 25'($urandom)};
      int c = $urandom_range(1, 8);
      if ($urandom_range(0, 1) == 1)
        do_write(a, c, 8'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                 (c > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, c - 1) : -1, 0);
      else
        do_read(a, c, first);
    end

    // RD and WE together: write taken, no read beats, sticky error
    do_write(WIN | 29'h040, 1, 8'hFF, 64'h5555_AAAA_5555_AAAA, 64'd0, -1, 1);
    saw = 0;
    for (int i = 0; i < RD_LAT + 2; i++) begin
      saw |= if0.DDRAM_DOUT_READY;
      @(negedge clk);
    end
    chkb("both_no_ready", saw, 1'b0);
    chkb("perr_both", perr0, 1'b1);
    do_read(WIN | 29'h040, 1, first);
    chk("both_write", first, 64'h5555_AAAA_5555_AAAA);
    reset_pulse();
    chkb("perr_cleared", perr0, 1'b0);
    do_write(WIN | 29'h041, 0, 8'hFF, 64'h0BAD_F00D_0000_0041, 64'd7, -1, 0);
    chkb("perr_zero_cnt", perr0, 1'b1);
    do_read(WIN | 29'h040, 3, first);
    chk("mem_kept", first, 64'h5555_AAAA_5555_AAAA);
    chkb("perr_sticky", perr0, 1'b1);

    // Reset during beat 2 of an 8-beat read
    wait_idle();
    if0.DDRAM_RD = 1'b1; if0.DDRAM_ADDR = WIN | 29'h100; if0.DDRAM_BURSTCNT = 8'd8;
    @(negedge clk);
    if0.DDRAM_RD = 1'b0;
    repeat (RD_LAT) @(negedge clk);
    chkb("mid_beat1", if0.DDRAM_DOUT_READY, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chkb("mid_rst_ready", if0.DDRAM_DOUT_READY, 1'b0);
    chkb("mid_rst_busy", if0.DDRAM_BUSY, 1'b1);
    chk("mid_rst_dout", if0.DDRAM_DOUT, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chkb("mid_rel_busy", if0.DDRAM_BUSY, 1'b0);
    saw = 0;
    for (int i = 0; i < 12; i++) begin
      saw |= if0.DDRAM_DOUT_READY;
      @(negedge clk);
    end
    chkb("mid_no_residual", saw, 1'b0);
    chkb("mid_perr", perr0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
